// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC and returns the instruction at PC over the RAM burst read channel.
// Define FETCH_LINE_BUF_EN to add a one-line instruction buffer with a LOOKUP hit path.
module instruction_fetch #(
  parameter int          AWIDTH     = 32,
  parameter int          DWIDTH     = 32,
  parameter int          LWIDTH     = 8,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_we,
  input  logic [31:0]       pc_next,
  input  logic              invalidate,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              done,
  output logic              fetch_err,
  output logic [AWIDTH-1:0] ram_araddr,
  output logic [LWIDTH-1:0] ram_arlen,
  output logic              ram_arvalid,
  input  logic              ram_arready,
  input  logic [DWIDTH-1:0] ram_rdata,
  input  logic              ram_rvalid,
  output logic              ram_rready,
  input  logic              ram_rlast
);

  localparam int          IW  = $clog2(LINE_WORDS);
  localparam int          OFS = IW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, LOOKUP, ADDR, DATA, DONE} state_t;

  state_t            state_q;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q;
  logic              done_q;
  logic              fetchErr_q;
  logic [AWIDTH-1:0] araddr_q;
  logic [LWIDTH-1:0] arlen_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [IW-1:0]     beatCnt_q;

`ifdef FETCH_LINE_BUF_EN
  localparam int TW = 32 - OFS;
  logic [DWIDTH-1:0] line_q [LINE_WORDS];
  logic [TW-1:0]     tag_q;
  logic              lineValid_q;
  logic              invPend_q;
  logic [TW-1:0]     pcTag;
  logic [IW-1:0]     pcIdx;

  assign pcTag = pc_q[31:OFS];
  assign pcIdx = pc_q[OFS-1:2];
`else
  logic unusedInvalidate;
  assign unusedInvalidate = invalidate;
`endif

  // A PC load in IDLE takes priority over a same-cycle start, so the fetch sees pc_next.
  always_comb begin
    pc_d = pc_q;
    if (state_q == IDLE && pc_we) pc_d = pc_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      done_q     <= 1'b0;
      fetchErr_q <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      beatCnt_q  <= '0;
`ifdef FETCH_LINE_BUF_EN
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
      tag_q       <= '0;
      lineValid_q <= 1'b0;
      invPend_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef FETCH_LINE_BUF_EN
      if (invalidate && state_q != DATA) lineValid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          pc_q <= pc_d;
          if (start) begin
            fetchErr_q <= 1'b0;
            if (pc_d[1:0] != 2'b00) begin
              fetchErr_q <= 1'b1;
              inst_q     <= NOP;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
`ifdef FETCH_LINE_BUF_EN
          if (lineValid_q && tag_q == pcTag) begin
            inst_q  <= 32'(line_q[pcIdx]);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            araddr_q  <= AWIDTH'({pc_q[31:OFS], {OFS{1'b0}}});
            arlen_q   <= LWIDTH'(LINE_WORDS - 1);
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
`else
          araddr_q  <= AWIDTH'(pc_q);
          arlen_q   <= '0;
          arvalid_q <= 1'b1;
          state_q   <= ADDR;
`endif
        end
        ADDR: begin
          if (ram_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beatCnt_q <= '0;
`ifdef FETCH_LINE_BUF_EN
            invPend_q <= 1'b0;
`endif
            state_q   <= DATA;
          end
        end
        DATA: begin
`ifdef FETCH_LINE_BUF_EN
          if (invalidate) invPend_q <= 1'b1;
          if (ram_rvalid && rready_q) begin
            line_q[beatCnt_q] <= ram_rdata;
            beatCnt_q         <= beatCnt_q + IW'(1);
            if (ram_rlast) begin
              // The word for the last beat is not in line_q yet, so forward it from the bus.
              if (beatCnt_q == IW'(LINE_WORDS - 1)) begin
                tag_q       <= pcTag;
                lineValid_q <= !(invPend_q || invalidate);
                inst_q      <= (pcIdx == beatCnt_q) ? 32'(ram_rdata) : 32'(line_q[pcIdx]);
              end else begin
                lineValid_q <= 1'b0;
                fetchErr_q  <= 1'b1;
                inst_q      <= NOP;
              end
              beatCnt_q <= '0;
              rready_q  <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end
`else
          if (ram_rvalid && rready_q) begin
            beatCnt_q <= beatCnt_q + IW'(1);
            if (beatCnt_q == '0) inst_q <= 32'(ram_rdata);
            if (!ram_rlast) begin
              fetchErr_q <= 1'b1;
            end else begin
              beatCnt_q <= '0;
              rready_q  <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign inst        = inst_q;
  assign done        = done_q;
  assign fetch_err   = fetchErr_q;
  assign ram_araddr  = araddr_q;
  assign ram_arlen   = arlen_q;
  assign ram_arvalid = arvalid_q;
  assign ram_rready  = rready_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; the RAM model returns 0xD000_0000 + byte address.
// Expectations follow FETCH_LINE_BUF_EN when it is defined.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        invalidate;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        done;
  logic        fetch_err;
  logic [31:0] ram_araddr;
  logic [7:0]  ram_arlen;
  logic        ram_arvalid;
  logic        ram_arready;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic        ram_rready;
  logic        ram_rlast;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_LINE_BUF_EN
  localparam int LEN = 3;
  localparam int NB  = 4;
`else
  localparam int LEN = 0;
  localparam int NB  = 1;
`endif

  instruction_fetch dut (
    .clk(clk), .rst(rst), .start(start), .pc_we(pc_we), .pc_next(pc_next),
    .invalidate(invalidate), .pc(pc), .inst(inst), .done(done), .fetch_err(fetch_err),
    .ram_araddr(ram_araddr), .ram_arlen(ram_arlen), .ram_arvalid(ram_arvalid),
    .ram_arready(ram_arready), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .ram_rready(ram_rready), .ram_rlast(ram_rlast)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hD000_0000 + a;
  endfunction

  function automatic logic [31:0] lineAddr(input logic [31:0] p);
`ifdef FETCH_LINE_BUF_EN
    return {p[31:4], 4'h0};
`else
    return p;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic doStart, input logic we, input logic [31:0] nxt, input logic inv);
    start      = doStart;
    pc_we      = we;
    pc_next    = nxt;
    invalidate = inv;
    tick();
    start      = 1'b0;
    pc_we      = 1'b0;
    invalidate = 1'b0;
  endtask

  // Waits for the address phase, optionally stalls arready, then returns nBeats beats.
  task automatic serveRead(input logic [31:0] fetchPc, input int hold, input int nBeats, input string tag);
    logic [31:0] base;
    base = lineAddr(fetchPc);
    for (int n = 0; n < 20 && ram_arvalid !== 1'b1; n++) tick();
    checkOutput({tag, "_arvalid"}, 32'(ram_arvalid), 32'd1);
    checkOutput({tag, "_araddr"}, ram_araddr, base);
    checkOutput({tag, "_arlen"}, 32'(ram_arlen), LEN);
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput({tag, "_holdArvalid"}, 32'(ram_arvalid), 32'd1);
      checkOutput({tag, "_holdAraddr"}, ram_araddr, base);
    end
    ram_arready = 1'b1;
    tick();
    ram_arready = 1'b0;
    checkOutput({tag, "_arDrop"}, 32'(ram_arvalid), 32'd0);
    for (int i = 0; i < nBeats; i++) begin
      for (int n = 0; n < 20 && ram_rready !== 1'b1; n++) tick();
      checkOutput({tag, "_rready"}, 32'(ram_rready), 32'd1);
      ram_rvalid = 1'b1;
      ram_rdata  = memWord(base + 32'(4 * i));
      ram_rlast  = (i == nBeats - 1);
      tick();
    end
    ram_rvalid = 1'b0;
    ram_rlast  = 1'b0;
    ram_rdata  = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pc_we = 1'b0; pc_next = '0; invalidate = 1'b0;
    ram_arready = 1'b0; ram_rdata = '0; ram_rvalid = 1'b0; ram_rlast = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
    checkOutput("rst_arvalid", 32'(ram_arvalid), 32'd0);
    checkOutput("rst_rready", 32'(ram_rready), 32'd0);
    checkOutput("rst_araddr", ram_araddr, 32'h0);
    checkOutput("rst_arlen", 32'(ram_arlen), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // Cold fetch at PC 0
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    serveRead(32'h0, 0, NB, "f0");
    checkOutput("f0_done", 32'(done), 32'd1);
    checkOutput("f0_inst", inst, memWord(32'h0));
    checkOutput("f0_err", 32'(fetch_err), 32'd0);
    tick();
    checkOutput("f0_donePulse", 32'(done), 32'd0);

    // Load PC 0x8 then fetch: a buffer hit when the line buffer is built in
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0);
    checkOutput("pcLoad", pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_LINE_BUF_EN
    checkOutput("hit_noAr0", 32'(ram_arvalid), 32'd0);
    tick();
    checkOutput("hit_noAr1", 32'(ram_arvalid), 32'd0);
`else
    serveRead(32'h8, 0, NB, "f8");
`endif
    checkOutput("f8_done", 32'(done), 32'd1);
    checkOutput("f8_inst", inst, memWord(32'h8));
    tick();

    // Same-cycle pc_we and start at 0x14, with arready stalled five cycles
    applyStimulus(1'b1, 1'b1, 32'h14, 1'b0);
    checkOutput("pcPriority", pc, 32'h14);
    serveRead(32'h14, 5, NB, "f14");
    checkOutput("f14_done", 32'(done), 32'd1);
    checkOutput("f14_inst", inst, memWord(32'h14));
    tick();

    // Misaligned PC
    applyStimulus(1'b1, 1'b1, 32'h6, 1'b0);
    checkOutput("mis_done", 32'(done), 32'd1);
    checkOutput("mis_err", 32'(fetch_err), 32'd1);
    checkOutput("mis_inst", inst, 32'h0000_0013);
    checkOutput("mis_noAr", 32'(ram_arvalid), 32'd0);
    tick();
    checkOutput("mis_donePulse", 32'(done), 32'd0);
    checkOutput("mis_errSticky", 32'(fetch_err), 32'd1);

    // Short burst at 0x20, then retry at the same PC
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b0);
    serveRead(32'h20, 0, 2, "short");
    checkOutput("short_done", 32'(done), 32'd1);
    checkOutput("short_err", 32'(fetch_err), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("retry_errClr", 32'(fetch_err), 32'd0);
    serveRead(32'h20, 0, NB, "retry");
    checkOutput("retry_done", 32'(done), 32'd1);
    checkOutput("retry_inst", inst, memWord(32'h20));
    checkOutput("retry_err", 32'(fetch_err), 32'd0);
    tick();

    // Reset asserted while a burst is in flight
    applyStimulus(1'b1, 1'b1, 32'h30, 1'b0);
    for (int n = 0; n < 20 && ram_arvalid !== 1'b1; n++) tick();
    checkOutput("abort_arvalid", 32'(ram_arvalid), 32'd1);
    ram_arready = 1'b1;
    tick();
    ram_arready = 1'b0;
    checkOutput("abort_rready", 32'(ram_rready), 32'd1);
    ram_rvalid = 1'b1;
    ram_rdata  = memWord(32'h30);
    ram_rlast  = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_arvalidLow", 32'(ram_arvalid), 32'd0);
    checkOutput("abort_rreadyLow", 32'(ram_rready), 32'd0);
    checkOutput("abort_pc", pc, 32'h0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err", 32'(fetch_err), 32'd0);
    ram_rvalid = 1'b0;
    #2 rst = 1'b1;
    tick();

    // Invalidate plus PC load, then fetch at 0x8 must go to RAM again
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    serveRead(32'h8, 0, NB, "refetch");
    checkOutput("refetch_done", 32'(done), 32'd1);
    checkOutput("refetch_inst", inst, memWord(32'h8));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
